// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Function : Doubleword-aligned load/store unit: sub-word load extract and
//             read-modify-write stores. Optional misalignment trap is enabled
//             by defining LSU_MISALIGN_TRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [2:0]          req_funct3_i,
  input  logic [WORDSIZE-1:0] req_addr_i,
  input  logic [WORDSIZE-1:0] req_wdata_i,
  output logic                resp_valid_o,
  output logic [WORDSIZE-1:0] resp_rdata_o,
  output logic                resp_fault_o,
  output logic [WORDSIZE-1:0] mem_addr_o,
  output logic [WORDSIZE-1:0] mem_wdata_o,
  output logic                mem_write_en_o,
  input  logic [WORDSIZE-1:0] mem_rdata_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [2:0]          funct3_q;
  logic                write_q;
  logic                fault_q;
  logic [2:0]          off_q;
  logic [WORDSIZE-1:0] addr_q;
  logic [WORDSIZE-1:0] wdata_q;
  logic [WORDSIZE-1:0] old_q;

  logic                accept;
  logic                req_illegal;
  logic                req_misalign;
  logic                req_fault;
  logic [2:0]          req_off;
  logic [WORDSIZE-1:0] shifted;
  logic [WORDSIZE-1:0] load_data;
  logic [WORDSIZE-1:0] mask;
  logic [WORDSIZE-1:0] merged;

  assign accept      = req_valid_i && req_ready_o;
  assign req_illegal = req_write_i ? req_funct3_i[2] : (req_funct3_i == 3'b111);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_off = req_addr_i[2:0];
    case (req_funct3_i[1:0])
      2'd1:    req_misalign = req_addr_i[0];
      2'd2:    req_misalign = |req_addr_i[1:0];
      2'd3:    req_misalign = |req_addr_i[2:0];
      default: req_misalign = 1'b0;
    endcase
  end
`else
  // Without the trap, low offset bits below the access size are dropped.
  always_comb begin
    req_misalign = 1'b0;
    case (req_funct3_i[1:0])
      2'd1:    req_off = {req_addr_i[2:1], 1'b0};
      2'd2:    req_off = {req_addr_i[2], 2'b00};
      2'd3:    req_off = 3'b000;
      default: req_off = req_addr_i[2:0];
    endcase
  end
`endif

  assign req_fault = req_illegal || req_misalign;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_fault)                                 state_d = S_RESP;
          else if (req_write_i && req_funct3_i == 3'b011) state_d = S_WRITE;
          else                                           state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = write_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      funct3_q <= '0;
      write_q  <= 1'b0;
      fault_q  <= 1'b0;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
    end else begin
      if (accept) begin
        funct3_q <= req_funct3_i;
        write_q  <= req_write_i;
        fault_q  <= req_fault;
        off_q    <= req_off;
        addr_q   <= {req_addr_i[WORDSIZE-1:3], 3'b000};
        wdata_q  <= req_wdata_i;
      end
      if (state_q == S_WAIT) old_q <= mem_rdata_i;
    end
  end

  assign shifted = old_q >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_data = old_q;
      3'b100:  load_data = {56'd0, shifted[7:0]};
      3'b101:  load_data = {48'd0, shifted[15:0]};
      3'b110:  load_data = {32'd0, shifted[31:0]};
      default: load_data = '0;
    endcase
  end

  // A full-width SD mask makes the merge degenerate to the store data.
  always_comb begin
    case (funct3_q[1:0])
      2'd0:    mask = 64'h0000_0000_0000_00FF << {off_q, 3'b000};
      2'd1:    mask = 64'h0000_0000_0000_FFFF << {off_q, 3'b000};
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF << {off_q, 3'b000};
      default: mask = '1;
    endcase
  end

  assign merged = (old_q & ~mask) | ((wdata_q << {off_q, 3'b000}) & mask);

  always_comb begin
    req_ready_o    = rst_n_i && (state_q == S_IDLE);
    mem_write_en_o = rst_n_i && (state_q == S_WRITE);
    resp_valid_o   = rst_n_i && (state_q == S_RESP);
    mem_addr_o     = addr_q;
    mem_wdata_o    = (state_q == S_WRITE) ? merged : '0;
    resp_fault_o   = resp_valid_o && fault_q;
    resp_rdata_o   = (resp_valid_o && !fault_q && !write_q) ? load_data : '0;
  end

endmodule
`default_nettype wire
